// File: rtl/ones_counter_sequencer.sv
// Job sequencer in front of the ones-counter ASMD: loads the operand while start is low, raises
// start, waits for done, captures the count and returns it through a valid/ready port.
module ones_counter_sequencer #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned W      = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          start,
  output logic [N-1:0]  a_out,
  input  logic          done_in,
  input  logic [W-1:0]  result_in,
  output logic          out_valid,
  output logic [W-1:0]  out_result,
  input  logic          out_ready,
  output logic          busy,
  output logic          err_timeout,
  output logic [15:0]   job_count
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StHold,
    StDrain
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [W-1:0]     res_q, res_d;
  logic [15:0]      jobs_q, jobs_d;
  logic             err_q, err_d;
  logic [WdogW-1:0] wdog_q, wdog_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      res_q   <= '0;
      jobs_q  <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      res_q   <= res_d;
      jobs_q  <= jobs_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    res_d   = res_q;
    jobs_d  = jobs_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_data;
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Counter sees start low for one cycle with A stable, so it loads the operand.
        wdog_d  = '0;
        state_d = StRun;
      end
      StRun: begin
        wdog_d = wdog_q + WdogW'(1);
        if (done_in) begin
          res_d   = result_in;
          jobs_d  = jobs_q + 16'd1;
          state_d = StHold;
        end else if (wdog_q == WdogLast) begin
          err_d   = 1'b1;
          state_d = StDrain;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign in_ready    = (state_q == StIdle);
  assign start       = (state_q == StRun);
  assign out_valid   = (state_q == StHold);
  assign busy        = (state_q != StIdle);
  assign a_out       = a_q;
  assign out_result  = res_q;
  assign err_timeout = err_q;
  assign job_count   = jobs_q;

endmodule

// File: tb/tb_ones_counter_sequencer.sv
// Bench for ones_counter_sequencer: behavioural ones-counter attached, directed jobs, scoreboard
// queue filled at acceptance and drained by a monitor on each output handshake.
module tb_ones_counter_sequencer;

  localparam int unsigned N       = 8;
  localparam int unsigned W       = 4;
  localparam int unsigned TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         start;
  logic [N-1:0] a_out;
  logic         done_in;
  logic [W-1:0] result_in;
  logic         out_valid;
  logic [W-1:0] out_result;
  logic         out_ready;
  logic         busy;
  logic         err_timeout;
  logic [15:0]  job_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic no_done = 1'b0;

  always #5 clk = ~clk;

  ones_counter_sequencer #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .a_out      (a_out),
    .done_in    (done_in),
    .result_in  (result_in),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_ready  (out_ready),
    .busy       (busy),
    .err_timeout(err_timeout),
    .job_count  (job_count)
  );

  // Ones-counter ASMD model: load A while s is low, shift/count while s is high, hold done.
  logic [1:0]   c_st;
  logic [N-1:0] c_a;
  logic [W-1:0] c_res;

  always @(posedge clk) begin
    if (reset) begin
      c_st  <= 2'd0;
      c_a   <= '0;
      c_res <= '0;
    end else begin
      case (c_st)
        2'd0: begin
          if (!start) begin
            c_a   <= a_out;
            c_res <= '0;
          end else begin
            c_st <= 2'd1;
          end
        end
        2'd1: begin
          if (c_a == '0) begin
            c_st <= 2'd2;
          end else begin
            c_res <= c_res + {{(W-1){1'b0}}, c_a[0]};
            c_a   <= c_a >> 1;
          end
        end
        default: begin
          if (!start) c_st <= 2'd0;
        end
      endcase
    end
  end

  assign done_in   = (c_st == 2'd2) && !no_done;
  assign result_in = c_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_job(input logic [N-1:0] d, input int exp, input bit want_result);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !in_ready; i++) tick();
    check("in_ready_wait", in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    if (want_result) exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    check("accept_a_out", a_out, d);
    check("load_start_low", start, 0);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 300 && !out_valid; i++) tick();
    check("out_valid_seen", out_valid, 1);
  endtask

  // Monitor: scoreboard compare on each handshake, plus start low gap between jobs.
  initial begin
    logic prev_start;
    int   low_cnt;
    prev_start = 1'b0;
    low_cnt    = 0;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {28'd0, out_result}, 32'hFFFF_FFFF);
        end else begin
          check("sb_result", out_result, exp_q.pop_front());
        end
      end
      if (start) begin
        if (!prev_start) check("start_gap", low_cnt >= 1, 1);
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      prev_start = start;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int run_cycles;
    logic [N-1:0] b2b_data [3];
    int           b2b_exp  [3];
    b2b_data = '{8'h01, 8'h80, 8'hF0};
    b2b_exp  = '{1, 1, 4};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick(2);
    check("rst_in_ready", in_ready, 1);
    check("rst_start", start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_job_count", job_count, 0);
    check("rst_err", err_timeout, 0);
    check("rst_a_out", a_out, 0);
    check("rst_out_result", out_result, 0);
    reset = 1'b0;
    tick();

    // A5: start rises one cycle after LOAD, result 4.
    out_ready = 1'b1;
    send_job(8'hA5, 4, 1'b1);
    check("a5_busy", busy, 1);
    check("a5_in_ready", in_ready, 0);
    tick();
    check("a5_start_k2", start, 1);
    wait_valid();
    check("a5_start_hold", start, 0);
    tick();
    check("a5_job_count", job_count, 1);
    check("a5_idle", in_ready, 1);

    // 00: counter finishes almost at once.
    send_job(8'h00, 0, 1'b1);
    wait_valid();
    check("z_start_hold", start, 0);
    tick();

    // FF with downstream stalled: result held, new job ignored.
    out_ready = 1'b0;
    send_job(8'hFF, 8, 1'b1);
    wait_valid();
    in_valid = 1'b1;
    in_data  = 8'h11;
    for (int i = 0; i < 5; i++) begin
      check("ff_hold_valid", out_valid, 1);
      check("ff_hold_result", out_result, 8);
      check("ff_hold_in_ready", in_ready, 0);
      check("ff_hold_start", start, 0);
      tick();
    end
    in_valid = 1'b0;
    check("ff_a_out_stable", a_out, 8'hFF);
    out_ready = 1'b1;
    tick();
    check("ff_released", in_ready, 1);
    check("ff_job_count", job_count, 3);

    // Counter never answers: watchdog aborts after TIMEOUT RUN cycles.
    no_done = 1'b1;
    send_job(8'h55, 0, 1'b0);
    tick();
    run_cycles = 0;
    while (start && run_cycles < 200) begin
      run_cycles++;
      tick();
    end
    check("to_run_cycles", run_cycles, TIMEOUT);
    check("to_err", err_timeout, 1);
    check("to_drain_busy", busy, 1);
    check("to_no_valid", out_valid, 0);
    tick();
    check("to_idle", in_ready, 1);
    check("to_err_sticky", err_timeout, 1);
    check("to_job_count", job_count, 3);
    no_done = 1'b0;

    send_job(8'h0F, 4, 1'b1);
    check("0f_err_cleared", err_timeout, 0);
    wait_valid();
    tick();
    check("0f_job_count", job_count, 4);

    // Reset mid-run: job dropped; reset also clears the job counter.
    send_job(8'h3C, 0, 1'b0);
    tick(3);
    check("rr_running", start, 1);
    reset = 1'b1;
    tick();
    check("rr_start", start, 0);
    check("rr_busy", busy, 0);
    check("rr_out_valid", out_valid, 0);
    check("rr_job_count", job_count, 0);
    reset = 1'b0;
    tick();

    for (int j = 0; j < 3; j++) begin
      send_job(b2b_data[j], b2b_exp[j], 1'b1);
      wait_valid();
      tick();
    end
    check("b2b_job_count", job_count, 3);
    tick(2);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
